instr_encoder: RTL and testbench

- Program loader that turns decoded instruction descriptors back into 32-bit RV32I instruction words.
- Writes them to consecutive instruction-memory addresses; performs the inverse mapping of the control unit's field extraction.
- Sits between the test/boot loader and instruction memory, so programs can be supplied as fields rather than pre-assembled hex.
- Accepts one descriptor per cycle over a valid/ready handshake; flags out-of-range immediates, unknown kinds and address overflow.

---
 rtl/instr_encoder_pkg.sv | 46 ++++
 rtl/instr_pack.sv | 76 +++++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_pkg : shared kind codes, RV32I opcodes, state encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_encoder_pkg;

  typedef enum logic [3:0] {
    KIND_R     = 4'd0,
    KIND_I     = 4'd1,
    KIND_L     = 4'd2,
    KIND_S     = 4'd3,
    KIND_B     = 4'd4,
    KIND_LUI   = 4'd5,
    KIND_AUIPC = 4'd6,
    KIND_JAL   = 4'd7,
    KIND_JALR  = 4'd8
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  // True when v is representable as a two's-complement value of 'bits' width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack : combinational descriptor-to-RV32I packing with range checks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        imm_err_o,
  output logic        kind_err_o
);

  always_comb begin
    word_o     = '0;
    imm_err_o  = 1'b0;
    kind_err_o = 1'b0;
    case (kind_i)
      KIND_R: begin
        word_o = {1'b0, alt_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      end
      KIND_I: begin
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          word_o    = {1'b0, alt_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
          imm_err_o = |imm_i[31:5];
        end else begin
          word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
          imm_err_o = !fits_signed(imm_i, 12);
        end
      end
      KIND_L: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
        imm_err_o = !fits_signed(imm_i, 12);
      end
      KIND_JALR: begin
        word_o    = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
        imm_err_o = !fits_signed(imm_i, 12);
      end
      KIND_S: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
        imm_err_o = !fits_signed(imm_i, 12);
      end
      KIND_B: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        imm_err_o = !fits_signed(imm_i, 13) || imm_i[0];
      end
      KIND_LUI: begin
        word_o    = {imm_i[31:12], rd_i, OPC_LUI};
        imm_err_o = |imm_i[11:0];
      end
      KIND_AUIPC: begin
        word_o    = {imm_i[31:12], rd_i, OPC_AUIPC};
        imm_err_o = |imm_i[11:0];
      end
      KIND_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        imm_err_o = !fits_signed(imm_i, 21) || imm_i[0];
      end
      default: begin
        word_o     = NOP_WORD;
        kind_err_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder : loads descriptor stream into instruction memory as RV32I words. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_imm,
  output logic              err_kind,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              stop_q;
  logic              ovf_pend_q;
  logic              err_imm_q;
  logic              err_kind_q;
  logic              err_ovf_q;

  logic [31:0]       pack_word;
  logic              pack_imm_err;
  logic              pack_kind_err;
  logic              accept;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              ovf_d;

  instr_pack u_pack (
    .kind_i     (in_kind),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .alt_i      (in_alt),
    .imm_i      (in_imm),
    .word_o     (pack_word),
    .imm_err_o  (pack_imm_err),
    .kind_err_o (pack_kind_err)
  );

  assign in_ready = (state_q == ST_RUN) && !stop_q;
  assign accept   = in_valid && in_ready;

  // addr_q advances one edge after each write, so a back-to-back accept targets addr_q+1.
  assign wr_addr_d = we_q ? addr_q + 1'b1 : addr_q;
  assign ovf_d     = accept && !in_last && (wr_addr_d == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE_ADDR;
      count_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      stop_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      err_imm_q  <= 1'b0;
      err_kind_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      we_q <= accept;
      if (accept) begin
        wdata_q    <= pack_word;
        err_imm_q  <= err_imm_q | pack_imm_err;
        err_kind_q <= err_kind_q | pack_kind_err;
        if (in_last || ovf_d) stop_q <= 1'b1;
        if (ovf_d) ovf_pend_q <= 1'b1;
      end
      if (we_q) begin
        count_q <= count_q + 1'b1;
        if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
        if (stop_q) begin
          state_q <= ST_DONE;
          if (ovf_pend_q) err_ovf_q <= 1'b1;
        end
      end
      if (start && state_q != ST_RUN) begin
        state_q    <= ST_RUN;
        addr_q     <= BASE_ADDR;
        count_q    <= '0;
        stop_q     <= 1'b0;
        ovf_pend_q <= 1'b0;
        err_imm_q  <= 1'b0;
        err_kind_q <= 1'b0;
        err_ovf_q  <= 1'b0;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign word_count = count_q;
  assign err_imm    = err_imm_q;
  assign err_kind   = err_kind_q;
  assign err_ovf    = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder : directed scoreboard bench for instr_encoder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        in_ready_a, imem_we_a, busy_a, done_a, err_imm_a, err_kind_a, err_ovf_a;
  logic [9:0]  imem_addr_a;
  logic [31:0] imem_wdata_a;
  logic [10:0] word_count_a;

  logic        in_ready_b, imem_we_b, busy_b, done_b, err_imm_b, err_kind_b, err_ovf_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0]  word_count_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int exp_addr_a = 0;
  int nb = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
    .busy(busy_a), .done(done_a), .word_count(word_count_a),
    .err_imm(err_imm_a), .err_kind(err_kind_a), .err_ovf(err_ovf_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .busy(busy_b), .done(done_b), .word_count(word_count_b),
    .err_imm(err_imm_b), .err_kind(err_kind_b), .err_ovf(err_ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_we_a === 1'b1) begin
      if (qa.size() == 0) chk("wr_a_unexpected", imem_we_a, 0);
      else begin
        e = qa.pop_front();
        chk("addr_a", 64'(imem_addr_a), {22'd0, e[41:32]});
        chk("word_a", 64'(imem_wdata_a), {32'd0, e[31:0]});
      end
    end
    if (imem_we_b === 1'b1) begin
      if (qb.size() == 0) chk("wr_b_unexpected", imem_we_b, 0);
      else begin
        e = qb.pop_front();
        chk("addr_b", 64'(imem_addr_b), {30'd0, e[33:32]});
        chk("word_b", 64'(imem_wdata_b), {32'd0, e[31:0]});
      end
    end
  end

  task automatic start_pulse_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    exp_addr_a = 0;
  endtask

  task automatic send_a(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm, input logic last, input logic [31:0] exp_word);
    bit ok;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
    in_alt = alt; in_imm = imm; in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_a) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_a_timeout", in_ready_a, 1);
    else begin
      qa.push_back({32'(exp_addr_a), exp_word});
      exp_addr_a++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; start_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", in_ready_a, 0);
    chk("rst_we", imem_we_a, 0);
    chk("rst_addr", imem_addr_a, 0);
    chk("rst_wdata", imem_wdata_a, 0);
    chk("rst_busy_done", {busy_a, done_a}, 0);
    chk("rst_count", word_count_a, 0);
    chk("rst_errs", {err_imm_a, err_kind_a, err_ovf_a}, 0);

    // Session 1: add + addi(last), done timing
    start_pulse_a();
    chk("start_busy", busy_a, 1);
    chk("start_ready", in_ready_a, 1);
    send_a(KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'h002081B3);
    send_a(KIND_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h00500093);
    chk("last_ready_low", in_ready_a, 0);
    chk("done_not_yet", done_a, 0);
    @(posedge clk); #1;
    chk("done_n2", done_a, 1);
    chk("busy_after_done", busy_a, 0);
    chk("count_s1", word_count_a, 2);

    // Session 2: S, B, JAL, LUI, SRAI
    start_pulse_a();
    send_a(KIND_S,   5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8,           1'b0, 32'h0020A423);
    send_a(KIND_B,   5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFC,   1'b0, 32'hFE208EE3);
    send_a(KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8,           1'b0, 32'h008000EF);
    send_a(KIND_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000,   1'b0, 32'h123452B7);
    send_a(KIND_I,   5'd1, 5'd1, 5'd0, 3'b101, 1'b1, 32'd3,           1'b1, 32'h4030D093);
    @(posedge clk); #1;
    chk("count_s2", word_count_a, 5);
    chk("errs_s2", {err_imm_a, err_kind_a, err_ovf_a}, 0);

    // Session 3: error flags, words still written
    start_pulse_a();
    send_a(KIND_I, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096, 1'b0, 32'h00000093);
    chk("err_imm_set", err_imm_a, 1);
    chk("err_kind_clear", err_kind_a, 0);
    send_a(KIND_B, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 1'b0, 32'h00208163);
    send_a(4'hF,   5'd7, 5'd7, 5'd7, 3'b111, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h00000013);
    @(posedge clk); #1;
    chk("errs_s3", {err_imm_a, err_kind_a}, 2'b11);
    chk("count_s3", word_count_a, 3);

    // Session 4: start clears errors; gapped valid; start during accept ignored
    start_pulse_a();
    chk("errs_cleared", {err_imm_a, err_kind_a, err_ovf_a}, 0);
    send_a(KIND_I, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 32'h00100093);
    @(posedge clk); #1;
    start_a = 1'b1;
    send_a(KIND_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b0, 32'h002081B3);
    @(posedge clk); #1;
    chk("count_s4", word_count_a, 2);
    chk("addr_s4", imem_addr_a, 2);

    // Reset collides with an acceptable descriptor
    in_kind = KIND_I; in_rd = 5'd2; in_rs1 = 5'd0; in_imm = 32'd9; in_funct3 = 3'd0;
    in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_we", imem_we_a, 0);
    chk("rst_mid_state", {busy_a, done_a, in_ready_a}, 0);
    chk("rst_mid_addr_cnt", {imem_addr_a, word_count_a}, 0);
    chk("rst_mid_wdata", imem_wdata_a, 0);
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    start_pulse_a();
    send_a(KIND_I, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b1, 32'h00200093);
    @(posedge clk); #1;
    chk("post_rst_done", {done_a, word_count_a}, {1'b1, 11'd1});

    // Overflow with ADDR_W=2, continuous valid, no last
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    in_kind = KIND_I; in_rd = 5'd1; in_rs1 = 5'd0; in_funct3 = 3'd0; in_alt = 1'b0;
    in_imm = 32'd7; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready_b) begin
        qb.push_back({32'(nb), 32'h00700093});
        nb++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ovf_accepts", 64'(nb), 4);
    chk("ovf_flag", err_ovf_b, 1);
    chk("ovf_done", done_b, 1);
    chk("ovf_count", word_count_b, 4);
    chk("ovf_addr_nowrap", imem_addr_b, 3);
    chk("ovf_ready", in_ready_b, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("qa_drained", 64'(qa.size()), 0);
    chk("qb_drained", 64'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
